// File: rtl/m_prog_loader.sv
// UART program loader: receives [len_hi len_lo {4-byte BE words} xor_csum] and writes
// each word to instruction memory, holding the processor in reset until verified.
module m_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 12
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_rxd,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [31:0]       r_wdata,
  output logic              r_proc_rst,
  output logic              r_done,
  output logic              r_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned CAP   = 1 << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_LENH, L_LENL, L_DATA, L_CSUM, L_DONE, L_ERR} l_state_t;

  rx_state_t        rx_state, rx_next;
  l_state_t         l_state, l_next;
  logic             sync1, sync2, rxd_d;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]       rx_bit, rx_bit_d;
  logic [7:0]       rx_sh, rx_sh_d;
  logic             byte_stb, byte_stb_d, frame_err, frame_err_d;
  logic [15:0]      count, count_d;
  logic [31:0]      word_asm, word_asm_d;
  logic [1:0]       byte_idx, byte_idx_d;
  logic [IDX_W-1:0] wr_idx, wr_idx_d;
  logic [7:0]       csum, csum_d;
  logic             we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]      wdata_d;
  logic [15:0]      len_c;

  // UART receiver: falling edge arms, mid-bit sampling, byte strobe at mid stop bit
  always_comb begin
    rx_next     = rx_state;
    rx_cnt_d    = rx_cnt + CNT_W'(1);
    rx_bit_d    = rx_bit;
    rx_sh_d     = rx_sh;
    byte_stb_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rxd_d && !sync2) rx_next = RX_START;
      end
      RX_START: begin
        if (rx_cnt == CNT_W'(HALF - 1)) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_next  = sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          rx_cnt_d = '0;
          rx_sh_d  = {sync2, rx_sh[7:1]};
          rx_bit_d = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          rx_cnt_d = '0;
          rx_next  = RX_IDLE;
          if (sync2) byte_stb_d  = 1'b1;
          else       frame_err_d = 1'b1;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  assign len_c = {count[15:8], rx_sh};

  // Frame parser: length, word assembly and writes, checksum verification
  always_comb begin
    l_next     = l_state;
    count_d    = count;
    word_asm_d = word_asm;
    byte_idx_d = byte_idx;
    wr_idx_d   = wr_idx;
    csum_d     = csum;
    we_d       = 1'b0;
    addr_d     = r_addr;
    wdata_d    = r_wdata;
    if (frame_err && l_state != L_DONE && l_state != L_ERR) begin
      l_next = L_ERR;
    end else if (byte_stb) begin
      case (l_state)
        L_LENH: begin
          count_d = {rx_sh, count[7:0]};
          csum_d  = csum ^ rx_sh;
          l_next  = L_LENL;
        end
        L_LENL: begin
          count_d    = len_c;
          csum_d     = csum ^ rx_sh;
          byte_idx_d = '0;
          wr_idx_d   = '0;
          if (32'(len_c) > CAP)     l_next = L_ERR;
          else if (len_c == 16'd0)  l_next = L_CSUM;
          else                      l_next = L_DATA;
        end
        L_DATA: begin
          csum_d     = csum ^ rx_sh;
          word_asm_d = {word_asm[23:0], rx_sh};
          byte_idx_d = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            we_d     = 1'b1;
            addr_d   = ADDR_W'(wr_idx);
            wdata_d  = {word_asm[23:0], rx_sh};
            wr_idx_d = wr_idx + IDX_W'(1);
            if (32'(wr_idx) + 32'd1 == 32'(count)) l_next = L_CSUM;
          end
        end
        L_CSUM: l_next = (rx_sh == csum) ? L_DONE : L_ERR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      rxd_d      <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      byte_stb   <= 1'b0;
      frame_err  <= 1'b0;
      l_state    <= L_LENH;
      count      <= '0;
      word_asm   <= '0;
      byte_idx   <= '0;
      wr_idx     <= '0;
      csum       <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_proc_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      sync1      <= w_rxd;
      sync2      <= sync1;
      rxd_d      <= sync2;
      rx_state   <= rx_next;
      rx_cnt     <= rx_cnt_d;
      rx_bit     <= rx_bit_d;
      rx_sh      <= rx_sh_d;
      byte_stb   <= byte_stb_d;
      frame_err  <= frame_err_d;
      l_state    <= l_next;
      count      <= count_d;
      word_asm   <= word_asm_d;
      byte_idx   <= byte_idx_d;
      wr_idx     <= wr_idx_d;
      csum       <= csum_d;
      r_we       <= we_d;
      r_addr     <= addr_d;
      r_wdata    <= wdata_d;
      r_proc_rst <= (l_next != L_DONE);
      r_done     <= (l_next == L_DONE);
      r_err      <= (l_next == L_ERR);
    end
  end

endmodule

// File: doc/m_prog_loader.md
# m_prog_loader

Serial program loader that fills the processor's 4K-word instruction memory over a UART line before execution starts. It is the writing end of the instruction-memory port that `m_proc12` reads. It receives a framed byte stream of word count, big-endian instruction words and an XOR checksum. It emits one word-write per assembled word on a memory write port, and holds the processor in reset until the image has loaded and verified.

## Interface
Parameters:
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- ADDR_W, 12: word-address width of the target memory; capacity is 2^ADDR_W words.

Ports:
- w_clk  in  1  clock; single clock domain.
- w_rst_n  in  1  reset, asynchronous, active-low.
- w_rxd  in  1  UART receive line (8N1, LSB first, idle high); asynchronous to w_clk.
- r_we  out  1  memory write enable, one-cycle pulse per word.
- r_addr  out  ADDR_W  memory word address.
- r_wdata  out  32  memory write data.
- r_proc_rst  out  1  active-high reset to processor; high until successful load.
- r_done  out  1  image loaded and checksum matched (sticky).
- r_err  out  1  framing, length or checksum error (sticky).

## Operation
- w_rxd passes through a 2-flop synchronizer before any use. Idle-state value is 1.
- UART RX FSM states:
  - RX_IDLE: on a 1→0 transition of the synchronized line, go to RX_START.
  - RX_START: at CLKS_PER_BIT/2 (integer divide), resample. If the line is 0, go to RX_DATA; if 1, treat as a glitch and return to RX_IDLE with no byte.
  - RX_DATA: sample 8 bits, each CLKS_PER_BIT after the previous sample. The first bit received is bit 0.
  - RX_STOP: sample after CLKS_PER_BIT. If 1, emit a byte strobe and go to RX_IDLE; if 0, signal a framing error.
- Load FSM states, advanced by byte strobes:
  - L_LENH: latch count[15:8].
  - L_LENL: latch count[7:0].
    - count > 2^ADDR_W: go to L_ERR.
    - count = 0: go to L_CSUM.
    - otherwise: go to L_DATA.
  - L_DATA: shift the byte into a 32-bit assembler, MSB byte first. On the 4th byte of a word, write the word.
    - After the last word is written, go to L_CSUM.
  - L_CSUM: compare the received byte with the running XOR of all prior bytes, including both length bytes. Equal: go to L_DONE. Unequal: go to L_ERR.
  - L_DONE and L_ERR are terminal until reset; further bytes are ignored.
  - A framing error in any non-terminal state goes to L_ERR.
- Word writes:
  - r_wdata = the assembled word and r_addr = the word index.
  - Indices start at 0 and increment by 1 after each write.
  - r_addr holds its last value between writes.
- r_proc_rst = 1 in every state except L_DONE. r_done = (state == L_DONE). r_err = (state == L_ERR).

## Timing
- Reset values:
  - Outputs: r_we = 0, r_addr = 0, r_wdata = 0, r_proc_rst = 1, r_done = 0, r_err = 0.
  - Internal: FSMs at RX_IDLE and L_LENH, checksum 0, synchronizer flops 1.
- Reset assertion mid-frame aborts immediately, asynchronously, and restores all reset values. Any partial byte, word or count is discarded.
- Byte strobe occurs at the mid-stop-bit sample. That is 2 (sync) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the falling edge of w_rxd, ±1 cycle.
- Write pulse: r_we is high for exactly 1 cycle, the cycle after the 4th byte strobe of a word. r_addr and r_wdata are valid in that same cycle.
- r_done or r_err rises 1 cycle after the checksum byte strobe. r_proc_rst falls in the same cycle r_done rises.
- A length error asserts r_err 1 cycle after the L_LENL strobe.
- Back-to-back bytes with no idle time between the stop bit and the next start bit must be received correctly.
- Maximum image is 2^ADDR_W words. The address counter never wraps, because lengths above capacity are rejected.

## Test plan
(All scenarios use CLKS_PER_BIT = 8 and ADDR_W = 12.)
- Normal load: send bytes 00 02 20 14 00 00 00 00 00 20 16.
  - Expect write {addr 0, 0x20140000}, then write {addr 1, 0x00000020}.
  - Then r_done = 1, r_proc_rst = 0, r_err = 0.
- Bad checksum: send the same stream with a final byte of 17.
  - Expect both writes.
  - Then r_err = 1, r_done = 0, r_proc_rst stays 1.
- Empty image: send 00 00 00.
  - Expect no r_we pulses, then r_done = 1.
- Oversize length: send 10 01.
  - Expect r_err = 1 one cycle after the 2nd strobe, and no writes.
  - Subsequent bytes are ignored.
- Line faults:
  - A 3-cycle low glitch on w_rxd: no byte, no state change.
  - A byte with stop bit 0 during L_DATA: r_err = 1, no further writes.
- Reset mid-load: pulse w_rst_n low after 00 02 20 14 00, then send the full normal stream.
  - Expect all outputs to return to reset values during reset.
  - Then exactly the normal-load results, with addr starting at 0.
